score_keeper: RTL and testbench

Game-flow controller and score counter for Pong. It sits directly upstream of the score glyph renderer. It receives goal events from the ball/collision logic and start requests from the button conditioner, and produces the two score values that the renderer turns into digit glyphs at the fixed player and enemy score positions. It also sequences the match: wait for start, serve delay, play, then game over at `MAX_SCORE`.

---
 rtl/score_keeper.sv | 133 +++++++++++++
 tb/tb_score_keeper.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
`default_nettype none
// score_keeper: Pong match sequencer (start / serve delay / play / game over) and score counters.
// Revision: 1.0

module score_keeper #(
  parameter int MAX_SCORE   = 5,
  parameter int MAX_SCORE_W = 4,
  parameter int SERVE_DELAY = 60,
  parameter int DELAY_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   frame_i,
  input  logic                   p_goal_i,
  input  logic                   e_goal_i,
  output logic [MAX_SCORE_W-1:0] p_score_o,
  output logic [MAX_SCORE_W-1:0] e_score_o,
  output logic                   play_o,
  output logic                   serve_o,
  output logic                   game_over_o,
  output logic [1:0]             winner_o
);

  localparam logic [1:0] ST_WAIT_START = 2'd0;
  localparam logic [1:0] ST_SERVE_WAIT = 2'd1;
  localparam logic [1:0] ST_PLAY       = 2'd2;
  localparam logic [1:0] ST_GAME_OVER  = 2'd3;

  localparam logic [MAX_SCORE_W-1:0] SCORE_WIN  = MAX_SCORE_W'(MAX_SCORE);
  localparam logic [DELAY_W-1:0]     DELAY_LOAD = DELAY_W'(SERVE_DELAY);
  localparam logic [DELAY_W-1:0]     DELAY_LAST = DELAY_W'(1);

  logic [1:0]             state, state_nxt;
  logic [DELAY_W-1:0]     delay_cnt, delay_nxt;
  logic                   start_q;
  logic [MAX_SCORE_W-1:0] p_nxt, e_nxt;
  logic [1:0]             winner_nxt;
  logic                   serve_nxt;

  logic                   start_ev;
  logic                   p_only, e_only, both_goals;
  logic                   serve_now;
  logic [MAX_SCORE_W-1:0] p_inc, e_inc;

  // start_q resets high so a button held through reset is not mistaken for a press.
  assign start_ev   = start_i & ~start_q;
  assign p_only     = p_goal_i & ~e_goal_i;
  assign e_only     = e_goal_i & ~p_goal_i;
  assign both_goals = p_goal_i & e_goal_i;
  assign serve_now  = frame_i && (delay_cnt == DELAY_LAST);
  assign p_inc      = p_score_o + 1'b1;
  assign e_inc      = e_score_o + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_WAIT_START;
      delay_cnt   <= '0;
      start_q     <= 1'b1;
      p_score_o   <= '0;
      e_score_o   <= '0;
      winner_o    <= 2'b00;
      serve_o     <= 1'b0;
      play_o      <= 1'b0;
      game_over_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      delay_cnt   <= delay_nxt;
      start_q     <= start_i;
      p_score_o   <= p_nxt;
      e_score_o   <= e_nxt;
      winner_o    <= winner_nxt;
      serve_o     <= serve_nxt;
      play_o      <= (state_nxt == ST_PLAY);
      game_over_o <= (state_nxt == ST_GAME_OVER);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_START: if (start_ev) state_nxt = ST_SERVE_WAIT;
      ST_SERVE_WAIT: if (serve_now) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (p_only)
          state_nxt = (p_inc == SCORE_WIN) ? ST_GAME_OVER : ST_SERVE_WAIT;
        else if (e_only)
          state_nxt = (e_inc == SCORE_WIN) ? ST_GAME_OVER : ST_SERVE_WAIT;
        else if (both_goals)
          state_nxt = ST_SERVE_WAIT;
      end
      ST_GAME_OVER:  if (start_ev) state_nxt = ST_SERVE_WAIT;
      default:       state_nxt = ST_WAIT_START;
    endcase
  end

  // Next values for the registered outputs and the serve-delay counter.
  always_comb begin
    delay_nxt  = delay_cnt;
    p_nxt      = p_score_o;
    e_nxt      = e_score_o;
    winner_nxt = winner_o;
    serve_nxt  = 1'b0;
    case (state)
      ST_WAIT_START, ST_GAME_OVER: begin
        if (start_ev) begin
          p_nxt      = '0;
          e_nxt      = '0;
          winner_nxt = 2'b00;
          delay_nxt  = DELAY_LOAD;
        end
      end
      ST_SERVE_WAIT: begin
        if (frame_i) delay_nxt = delay_cnt - DELAY_LAST;
        serve_nxt = serve_now;
      end
      ST_PLAY: begin
        if (p_goal_i || e_goal_i) delay_nxt = DELAY_LOAD;
        if (p_only) begin
          p_nxt = p_inc;
          if (p_inc == SCORE_WIN) winner_nxt = 2'b01;
        end else if (e_only) begin
          e_nxt = e_inc;
          if (e_inc == SCORE_WIN) winner_nxt = 2'b10;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// tb_score_keeper: vector table plus hand sequences, expected outputs queued and checked a cycle later.

module tb_score_keeper;

  localparam int MAX = 5;
  localparam int DLY = 2;

  typedef struct {
    logic       s, f, p, e;
    logic [3:0] xp, xe;
    logic       xpl, xsv, xgo;
    logic [1:0] xw;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, frame = 1'b0, pg = 1'b0, eg = 1'b0;
  logic [3:0] p_score, e_score;
  logic       play, serve, game_over;
  logic [1:0] winner;
  logic [12:0] outs;

  always #5 clk = ~clk;

  score_keeper #(
    .MAX_SCORE(MAX), .MAX_SCORE_W(4), .SERVE_DELAY(DLY), .DELAY_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .frame_i(frame),
    .p_goal_i(pg), .e_goal_i(eg),
    .p_score_o(p_score), .e_score_o(e_score), .play_o(play),
    .serve_o(serve), .game_over_o(game_over), .winner_o(winner)
  );

  assign outs = {p_score, e_score, play, serve, game_over, winner};

  int          checks = 0;
  int          passes = 0;
  logic [12:0] exp_q[$];
  vec_t        vecs[$];

  // Reference match state used to fill in expected values.
  logic [3:0] cp = 0, ce = 0;
  logic       cpl = 0, cgo = 0;
  logic [1:0] cw = 0;

  function automatic vec_t mk(logic s, logic f, logic p, logic e, logic sv);
    vec_t r;
    r.s = s; r.f = f; r.p = p; r.e = e;
    r.xp = cp; r.xe = ce; r.xpl = cpl; r.xsv = sv; r.xgo = cgo; r.xw = cw;
    return r;
  endfunction

  function automatic logic [12:0] pk(vec_t x);
    return {x.xp, x.xe, x.xpl, x.xsv, x.xgo, x.xw};
  endfunction

  function automatic void v(logic s, logic f, logic p, logic e, logic sv);
    vecs.push_back(mk(s, f, p, e, sv));
  endfunction

  function automatic void serve_seq(logic noisy);
    v(0, 1, 0, 0, 0);
    if (noisy) begin
      v(0, 0, 1, 0, 0);
      v(1, 0, 0, 0, 0);
      v(0, 0, 0, 1, 0);
    end else begin
      repeat (3) v(0, 0, 0, 0, 0);
    end
    cpl = 1;
    v(0, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0);
  endfunction

  function automatic void goal(logic p, logic e, logic f, logic noisy);
    cpl = 0;
    if (p && !e) begin
      cp = cp + 1;
      if (cp == MAX) begin cgo = 1; cw = 2'b01; end
    end else if (e && !p) begin
      ce = ce + 1;
      if (ce == MAX) begin cgo = 1; cw = 2'b10; end
    end
    v(0, f, p, e, 0);
    if (!cgo) serve_seq(noisy);
  endfunction

  function automatic void press();
    v(0, 0, 0, 0, 0);
    cp = 0; ce = 0; cw = 0; cgo = 0; cpl = 0;
    v(1, 0, 0, 0, 0);
  endfunction

  task automatic compare(string nm, logic [12:0] got, logic [12:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got p=%0d e=%0d play=%b serve=%b go=%b win=%b, expected p=%0d e=%0d play=%b serve=%b go=%b win=%b",
                  nm, got[12:9], got[8:5], got[4], got[3], got[2], got[1:0],
                  want[12:9], want[8:5], want[4], want[3], want[2], want[1:0]);
  endtask

  task automatic step(vec_t x, string nm);
    start = x.s; frame = x.f; pg = x.p; eg = x.e;
    exp_q.push_back(pk(x));
    @(posedge clk);
    #1;
    compare(nm, outs, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    compare("reset_values", outs, 13'd0);
    @(posedge clk); #1;
    rst = 0;

    // Goals and frames before any start are ignored.
    v(0, 0, 1, 0, 0); v(0, 0, 0, 1, 0); v(0, 1, 0, 0, 0); v(0, 0, 1, 1, 0);
    // Start, then frames ten cycles apart; serve on the second frame.
    repeat (4) v(0, 0, 0, 0, 0);
    press();
    repeat (9) v(0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0);
    repeat (9) v(0, 0, 0, 0, 0);
    cpl = 1;
    v(0, 1, 0, 0, 1);
    v(0, 0, 0, 0, 0);
    // Player wins 5/0: frame coinciding with a goal, noise during serve wait, start during play.
    goal(1, 0, 0, 0);
    goal(1, 0, 1, 1);
    v(1, 0, 0, 0, 0);
    goal(1, 0, 0, 0);
    goal(1, 0, 0, 0);
    goal(1, 0, 0, 0);
    v(0, 0, 0, 1, 0); v(0, 1, 1, 0, 0); v(0, 0, 1, 1, 0);
    // Restart, reach 2/3, void point, then player wins 5/3.
    press(); serve_seq(0);
    goal(1, 0, 0, 0); goal(0, 1, 0, 0); goal(1, 0, 0, 0); goal(0, 1, 0, 0); goal(0, 1, 0, 0);
    goal(1, 1, 0, 0);
    goal(1, 0, 0, 0); goal(1, 0, 0, 0); goal(1, 0, 0, 0);
    // Restart from game over, enemy wins 0/5.
    press(); serve_seq(0);
    repeat (5) goal(0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset from game over clears outputs before the next edge.
    #2 rst = 1;
    #1 compare("async_reset", outs, 13'd0);
    start = 1;
    @(posedge clk); #1;
    rst = 0;
    cp = 0; ce = 0; cw = 0; cgo = 0; cpl = 0;

    // Start held through reset release is not a press.
    step(mk(1, 0, 0, 0, 0), "held_start");
    step(mk(1, 0, 0, 0, 0), "held_start");
    repeat (3) step(mk(1, 1, 0, 0, 0), "held_start_frame");
    step(mk(0, 0, 0, 0, 0), "release");
    step(mk(1, 0, 0, 0, 0), "press");
    step(mk(1, 1, 0, 0, 0), "frame_after_press");
    cpl = 1;
    step(mk(1, 1, 0, 0, 1), "serve_after_press");
    step(mk(0, 0, 0, 0, 0), "live");

    // Reset one frame before the serve: no serve afterwards.
    cpl = 0; cp = 1;
    step(mk(0, 0, 1, 0, 0), "goal_before_rst");
    step(mk(0, 1, 0, 0, 0), "frame_before_rst");
    #2 rst = 1;
    #1 compare("rst_in_serve_wait", outs, 13'd0);
    @(posedge clk); #1;
    rst = 0;
    cp = 0;
    repeat (3) step(mk(0, 1, 0, 0, 0), "frame_after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
